// File: rtl/tsv_link_pkg.sv
// tsv_link_pkg: shared frame sizing helpers and TX state type for the TSV link
package tsv_link_pkg;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    function automatic int frames_f(input int n_sig, input int n_tsv);
        return (n_sig + n_tsv - 1) / n_tsv;
    endfunction
    function automatic int idx_w_f(input int frames);
        return frames > 1 ? $clog2(frames) : 1;
    endfunction
    localparam int FRAMES_DEF = frames_f(32, 8);
    localparam int IDX_W_DEF = idx_w_f(FRAMES_DEF);
endpackage

// File: rtl/tsv_link_rx.sv
// tsv_link_rx: reassembles sliced frames from the vias, checks parity and counts dropped frames
module tsv_link_rx
    import tsv_link_pkg::*;
#(
    parameter int N_SIG = 32,
    parameter int N_TSV = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic [N_TSV-1:0] tsv_data_i,
    input  logic             tsv_sync_i,
    input  logic             tsv_par_i,
    output logic [N_SIG-1:0] sig_out,
    output logic             out_valid,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int FRAMES = frames_f(N_SIG, N_TSV);
    localparam int IW = idx_w_f(FRAMES);
    localparam int W = FRAMES * N_TSV;
    localparam logic [IW-1:0] LAST = IW'(FRAMES - 1);
    logic [W-1:0] asm_q, asm_d;
    logic [IW-1:0] cnt_q, cnt_d, idx;
    logic bad_q, bad_d, busy, take, last, frame_bad, deliver, err_ev;
    // a nonzero slice counter means a frame is in progress; sync always restarts at slice 0
    always_comb begin
        busy = cnt_q != '0;
        take = tsv_sync_i || busy;
        idx = tsv_sync_i ? '0 : cnt_q;
        last = take && idx == LAST;
        frame_bad = (!tsv_sync_i && bad_q) || (tsv_par_i != ^tsv_data_i);
        deliver = last && !frame_bad;
        err_ev = (tsv_sync_i && busy) || (last && frame_bad);
        asm_d = asm_q;
        if (take) asm_d[int'(idx)*N_TSV +: N_TSV] = tsv_data_i;
        cnt_d = take ? (last ? '0 : idx + 1'b1) : cnt_q;
        bad_d = take ? frame_bad : bad_q;
    end
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
            cnt_q <= '0;
            bad_q <= 1'b0;
            sig_out <= '0;
            out_valid <= 1'b0;
            err_cnt <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
            bad_q <= bad_d;
            out_valid <= deliver;
            if (deliver) sig_out <= asm_d[N_SIG-1:0];
            if (err_ev && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tsv_link_mux.sv
// tsv_link_mux: time-multiplexes a signal bundle over N_TSV vias plus sync and parity, with the RX half
module tsv_link_mux
    import tsv_link_pkg::*;
#(
    parameter int N_SIG = 32,
    parameter int N_TSV = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic [N_SIG-1:0] sig_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_TSV-1:0] tsv_data_o,
    output logic             tsv_sync_o,
    output logic             tsv_par_o,
    input  logic [N_TSV-1:0] tsv_data_i,
    input  logic             tsv_sync_i,
    input  logic             tsv_par_i,
    output logic [N_SIG-1:0] sig_out,
    output logic             out_valid,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int FRAMES = frames_f(N_SIG, N_TSV);
    localparam int IW = idx_w_f(FRAMES);
    localparam int W = FRAMES * N_TSV;
    localparam logic [IW-1:0] LAST = IW'(FRAMES - 1);
    tx_state_e state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [W-1:0] snap_q, snap_d, pad;
    logic send, accept;
    // accepting in the last slice restarts at slice 0 so frames run gap-free
    always_comb begin
        pad = '0;
        pad[N_SIG-1:0] = sig_in;
        send = state_q == TX_SEND;
        in_ready = !send || k_q == LAST;
        accept = in_valid && in_ready;
        state_d = accept ? TX_SEND : (in_ready ? TX_IDLE : state_q);
        k_d = accept ? '0 : (send ? k_q + 1'b1 : k_q);
        snap_d = accept ? pad : snap_q;
        tsv_data_o = send ? snap_q[int'(k_q)*N_TSV +: N_TSV] : '0;
        tsv_sync_o = send && k_q == '0;
        tsv_par_o = ^tsv_data_o;
    end
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            k_q <= '0;
            snap_q <= '0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            snap_q <= snap_d;
        end
    end
    tsv_link_rx #(.N_SIG(N_SIG), .N_TSV(N_TSV), .ERR_W(ERR_W)) u_rx (
        .clk1(clk1),
        .rst_n(rst_n),
        .tsv_data_i(tsv_data_i),
        .tsv_sync_i(tsv_sync_i),
        .tsv_par_i(tsv_par_i),
        .sig_out(sig_out),
        .out_valid(out_valid),
        .err_cnt(err_cnt)
    );
endmodule

// File: tb/tb_tsv_link_mux.sv
// tb_tsv_link_mux: looped-back link with injected via faults, checked against a queue-based bundle model
module tb_tsv_link_mux;
    localparam int FRAMES = 4;
    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;
    logic [31:0] sig_in = '0;
    logic in_valid = 1'b0;
    logic in_ready, tsv_sync_o, tsv_par_o, out_valid;
    logic [7:0] tsv_data_o, err_cnt;
    logic [31:0] sig_out;
    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;
    int flip_cyc = -1;
    int sync_cyc = -1;
    bit sync_all = 1'b0;
    bit par_all = 1'b0;
    wire tsv_sync_i = tsv_sync_o | (cyc == sync_cyc) | sync_all;
    wire tsv_par_i = tsv_par_o ^ ((cyc == flip_cyc) | par_all);

    tsv_link_mux dut (
        .clk1(clk1), .rst_n(rst_n), .sig_in(sig_in), .in_valid(in_valid), .in_ready(in_ready),
        .tsv_data_o(tsv_data_o), .tsv_sync_o(tsv_sync_o), .tsv_par_o(tsv_par_o),
        .tsv_data_i(tsv_data_o), .tsv_sync_i(tsv_sync_i), .tsv_par_i(tsv_par_i),
        .sig_out(sig_out), .out_valid(out_valid), .err_cnt(err_cnt)
    );

    logic [9:0] s10 = '0;
    logic v10 = 1'b0;
    logic a_rdy, a_sync, a_par, a_ov, b_rdy, b_sync, b_par, b_ov;
    logic [3:0] a_data;
    logic [15:0] b_data;
    logic [9:0] a_sig, b_sig;
    logic [7:0] a_err, b_err;
    tsv_link_mux #(.N_SIG(10), .N_TSV(4), .ERR_W(8)) dut_a (
        .clk1(clk1), .rst_n(rst_n), .sig_in(s10), .in_valid(v10), .in_ready(a_rdy),
        .tsv_data_o(a_data), .tsv_sync_o(a_sync), .tsv_par_o(a_par),
        .tsv_data_i(a_data), .tsv_sync_i(a_sync), .tsv_par_i(a_par),
        .sig_out(a_sig), .out_valid(a_ov), .err_cnt(a_err)
    );
    tsv_link_mux #(.N_SIG(10), .N_TSV(16), .ERR_W(8)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .sig_in(s10), .in_valid(v10), .in_ready(b_rdy),
        .tsv_data_o(b_data), .tsv_sync_o(b_sync), .tsv_par_o(b_par),
        .tsv_data_i(b_data), .tsv_sync_i(b_sync), .tsv_par_i(b_par),
        .sig_out(b_sig), .out_valid(b_ov), .err_cnt(b_err)
    );

    typedef struct {logic [31:0] d; int c;} exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;
    int exp_err = 0;
    logic [31:0] last_good = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk1) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) check("spurious_out_valid", 1, 0);
            else begin
                e = q.pop_front();
                check("sig_out", sig_out, e.d);
                check("latency", cyc - e.c, FRAMES + 1);
            end
        end
    end

    task automatic send(input logic [31:0] v, output int t);
        int n = 0;
        @(negedge clk1);
        sig_in = v;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        t = cyc;
        @(posedge clk1);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk1);
            n++;
        end
        check("drain", q.size(), 0);
        repeat (3) @(negedge clk1);
    endtask

    function automatic int sat(input int x);
        return x > 255 ? 255 : x;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t2;
        logic [31:0] v;
        logic [11:0] v12;
        repeat (2) @(negedge clk1);
        check("rst_in_ready", in_ready, 1);
        check("rst_tsv_o", {tsv_data_o, tsv_sync_o, tsv_par_o}, 0);
        check("rst_sig_out", sig_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;

        v = 32'hDEADBEEF;
        send(v, t);
        q.push_back('{v, t});
        for (int k = 0; k < FRAMES; k++) begin
            check("slice_data", tsv_data_o, v[8*k +: 8]);
            check("slice_sync", tsv_sync_o, k == 0);
            check("slice_par", tsv_par_o, ^v[8*k +: 8]);
            @(posedge clk1);
            #1;
        end
        check("idle_data", {tsv_data_o, tsv_sync_o, tsv_par_o}, 0);
        drain();
        last_good = v;

        send(32'h11111111, t);
        q.push_back('{32'h11111111, t});
        send(32'h22222222, t2);
        q.push_back('{32'h22222222, t2});
        check("b2b_gap", t2 - t, FRAMES);
        drain();
        last_good = 32'h22222222;

        send(32'hCAFEF00D, t);
        flip_cyc = t + 3;
        exp_err++;
        repeat (8) @(negedge clk1);
        check("par_err_cnt", err_cnt, exp_err);
        check("par_sig_hold", sig_out, last_good);
        v = $urandom;
        send(v, t);
        q.push_back('{v, t});
        drain();
        last_good = v;

        v = $urandom;
        send(v, t);
        sync_cyc = t + 3;
        q.push_back('{v >> 16, t + 2});
        exp_err++;
        drain();
        check("sync_err_cnt", err_cnt, exp_err);
        last_good = v >> 16;

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk1);
            v = $urandom;
            send(v, t);
            if ($urandom_range(0, 5) == 0) begin
                flip_cyc = t + 1 + int'($urandom_range(0, 3));
                exp_err = sat(exp_err + 1);
            end else begin
                q.push_back('{v, t});
                last_good = v;
            end
        end
        drain();
        check("rand_err_cnt", err_cnt, exp_err);
        check("rand_sig_hold", sig_out, last_good);

        send($urandom, t);
        @(posedge clk1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_tsv_o", {tsv_data_o, tsv_sync_o, tsv_par_o}, 0);
        check("mid_rst_sig_out", sig_out, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        exp_err = 0;
        last_good = '0;
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk1);
        check("post_rst_sig_out", sig_out, last_good);
        check("post_rst_err_cnt", err_cnt, exp_err);

        sync_all = 1'b1;
        par_all = 1'b1;
        repeat (300) @(negedge clk1);
        sync_all = 1'b0;
        repeat (6) @(negedge clk1);
        par_all = 1'b0;
        exp_err = sat(exp_err + 300);
        check("sat_err_cnt", err_cnt, exp_err);
        for (int i = 0; i < 3; i++) begin
            send($urandom, t);
            flip_cyc = t + 2;
            exp_err = sat(exp_err + 1);
            repeat (6) @(negedge clk1);
        end
        check("sat_hold_err_cnt", err_cnt, exp_err);
        check("sat_sig_hold", sig_out, last_good);
        v = $urandom;
        send(v, t);
        q.push_back('{v, t});
        drain();

        @(negedge clk1);
        s10 = 10'h3A5;
        v10 = 1'b1;
        v12 = {2'b00, s10};
        check("n10_ready", {a_rdy, b_rdy}, 2'b11);
        @(posedge clk1);
        #1 v10 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("n10_slice", a_data, v12[4*k +: 4]);
            check("n10_sync", a_sync, k == 0);
            if (k == 0) check("n16_slice", {b_sync, b_data}, {1'b1, 6'd0, s10});
            if (k == 1) check("n16_out", {b_ov, b_sig}, {1'b1, s10});
            @(posedge clk1);
            #1;
        end
        check("n10_out", {a_ov, a_sig}, {1'b1, s10});
        check("n10_err", {a_err, b_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
